// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums a frame of unsigned products coming from an upstream multiplier and
// presents the saturated frame sum, the saturated beat count and an overflow
// flag once the last beat of the frame has been accepted.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both 1.  A valid source keeps its payload stable until
// that edge.  in_ready and out_valid are never both 1.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   product beat present
//   in_ready   block can accept a beat (state ACCUM)
//   in_p       unsigned product, 2*SIZE bits
//   in_last    the beat closes the frame
//   out_valid  frame result available (state HOLD)
//   out_ready  consumer accepts the result
//   out_sum    saturated frame sum
//   out_count  saturated beat count of the frame
//   out_ovf    frame sum saturated
//   dbg_state  current FSM state (0 = ACCUM, 1 = HOLD)
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int SIZE      = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*SIZE-1:0]    in_p,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf,
    output logic                 dbg_state
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   ovf;

    logic                   accept;
    logic [ACC_WIDTH:0]     sum_wide;
    logic [ACC_WIDTH-1:0]   sum_next;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   ovf_next;

    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    // Running values including the beat currently on in_p.  The extra carry
    // bit of sum_wide is the overflow indication; once acc is saturated any
    // non-zero product overflows again, so acc stays pinned at all ones.
    always_comb begin
        sum_wide = {1'b0, acc} + {{(ACC_WIDTH + 1 - 2*SIZE){1'b0}}, in_p};
        ovf_next = ovf | sum_wide[ACC_WIDTH];
        sum_next = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
        cnt_next = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            // Publish the frame and start the next one from zero.
                            out_sum   <= sum_next;
                            out_count <= cnt_next;
                            out_ovf   <= ovf_next;
                            acc       <= '0;
                            cnt       <= '0;
                            ovf       <= 1'b0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc <= sum_next;
                            cnt <= cnt_next;
                            ovf <= ovf_next;
                        end
                    end
                end
                HOLD: begin
                    // Input side is stalled; results stay frozen until taken.
                    if (out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Bench for product_accumulator with SIZE=4, ACC_WIDTH=10, CNT_WIDTH=8.
// Directed vector table, hand-written corner sequences, and randomized frames
// checked against a frame-level arithmetic model through an expected queue.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

    localparam int SIZE      = 4;
    localparam int ACC_WIDTH = 10;
    localparam int CNT_WIDTH = 8;
    localparam int RES_W     = ACC_WIDTH + CNT_WIDTH + 1;
    localparam int SUM_MAX   = (1 << ACC_WIDTH) - 1;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*SIZE-1:0]    in_p;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;
    logic                 dbg_state;

    always #5 clk = ~clk;

    product_accumulator #(
        .SIZE(SIZE), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame total kept as a plain integer; the result is the clipped total.
    logic [RES_W-1:0] exp_q[$];
    int cur_total = 0;
    int cur_beats = 0;

    task automatic model_accept(input int p, input bit last);
        int s;
        int c;
        cur_total += p;
        cur_beats += 1;
        if (last) begin
            s = (cur_total > SUM_MAX) ? SUM_MAX : cur_total;
            c = (cur_beats > CNT_MAX) ? CNT_MAX : cur_beats;
            exp_q.push_back({ACC_WIDTH'(s), CNT_WIDTH'(c), cur_total > SUM_MAX});
            cur_total = 0;
            cur_beats = 0;
        end
    endtask

    task automatic model_reset();
        cur_total = 0;
        cur_beats = 0;
        exp_q.delete();
    endtask

    // ---------------- out_ready driver ----------------
    bit rand_mode   = 1'b0;
    bit ready_force = 1'b1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // ---------------- scoreboard / monitor ----------------
    bit               hold_prev = 1'b0;
    logic [RES_W-1:0] held_val;

    always @(negedge clk) begin
        logic [RES_W-1:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("result", 32'({out_sum, out_count, out_ovf}), 32'(e));
            end
        end
        if (rst_n && hold_prev && out_valid)
            check("hold_stable", 32'({out_sum, out_count, out_ovf}), 32'(held_val));
        hold_prev = rst_n && out_valid && !out_ready;
        held_val  = {out_sum, out_count, out_ovf};
    end

    // ---------------- driver ----------------
    task automatic send_beat(input int p, input bit last);
        bit r;
        int n;
        r = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_p     = 8'(p);
        in_last  = last;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) check("accept_timeout", 32'(0), 32'(1));
        else    model_accept(p, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int p;
        bit last;
        bit chk;
        int sum;
        int cnt;
        bit ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int len;
        int w;

        tbl[0] = '{6,   1'b0, 1'b0, 0,    0, 1'b0};
        tbl[1] = '{20,  1'b0, 1'b0, 0,    0, 1'b0};
        tbl[2] = '{225, 1'b1, 1'b1, 251,  3, 1'b0};
        tbl[3] = '{225, 1'b0, 1'b0, 0,    0, 1'b0};
        tbl[4] = '{225, 1'b0, 1'b0, 0,    0, 1'b0};
        tbl[5] = '{225, 1'b0, 1'b0, 0,    0, 1'b0};
        tbl[6] = '{225, 1'b0, 1'b0, 0,    0, 1'b0};
        tbl[7] = '{225, 1'b1, 1'b1, 1023, 5, 1'b1};
        tbl[8] = '{9,   1'b1, 1'b1, 9,    1, 1'b0};
        tbl[9] = '{0,   1'b1, 1'b1, 0,    1, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_p     = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_sum",   32'(out_sum),   32'(0));
        check("rst_out_count", 32'(out_count), 32'(0));
        check("rst_out_ovf",   32'(out_ovf),   32'(0));

        // Table: frames with result checked one cycle after the last beat,
        // then a single bubble before in_ready returns.
        for (int i = 0; i < 10; i++) begin
            send_beat(tbl[i].p, tbl[i].last);
            if (tbl[i].chk) begin
                check("tbl_out_valid", 32'(out_valid), 32'(1));
                check("tbl_in_ready",  32'(in_ready),  32'(0));
                check("tbl_sum",       32'(out_sum),   32'(tbl[i].sum));
                check("tbl_count",     32'(out_count), 32'(tbl[i].cnt));
                check("tbl_ovf",       32'(out_ovf),   32'(tbl[i].ovf));
                @(posedge clk);
                #1;
                check("tbl_bubble_in_ready",  32'(in_ready),  32'(1));
                check("tbl_bubble_out_valid", 32'(out_valid), 32'(0));
            end
        end

        // Stalled consumer: beats offered during HOLD must not be absorbed.
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_beat(100, 1'b1);
        in_valid = 1'b1;
        in_p     = 8'd77;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready),  32'(0));
            check("stall_out_valid", 32'(out_valid), 32'(1));
            check("stall_sum",       32'(out_sum),   32'(100));
        end
        ready_force = 1'b1;
        send_beat(77, 1'b1);
        check("after_stall_sum",   32'(out_sum),   32'(77));
        check("after_stall_count", 32'(out_count), 32'(1));
        @(posedge clk);
        #1;

        // Reset in the middle of a frame discards the partial sum.
        send_beat(100, 1'b0);
        send_beat(50, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check("midrst_in_ready",  32'(in_ready),  32'(1));
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_sum",   32'(out_sum),   32'(0));
        send_beat(7, 1'b1);
        check("midrst_sum",   32'(out_sum),   32'(7));
        check("midrst_count", 32'(out_count), 32'(1));
        @(posedge clk);
        #1;

        // Randomized frames with random consumer back-pressure.
        rand_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            for (int b = 0; b < len; b++) begin
                w = $urandom_range(0, 2);
                repeat (w) @(posedge clk);
                #1;
                send_beat((f % 5 == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255),
                          b == len - 1);
            end
        end
        rand_mode   = 1'b0;
        ready_force = 1'b1;

        // Long frame: count saturates, sum does not.
        for (int b = 0; b < 300; b++)
            send_beat(1, b == 299);
        check("long_count", 32'(out_count), 32'(255));
        check("long_sum",   32'(out_sum),   32'(300));
        check("long_ovf",   32'(out_ovf),   32'(0));

        // Drain outstanding results.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
